// File: rtl/flag_reg_pkg.sv
// Shared defaults, flag bit names and the level-width helper for the flag register stack.
package flag_reg_pkg;

    localparam int DEF_NR_OF_FLAGS = 4;
    localparam int DEF_STACK_DEPTH = 4;

    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    // Bits needed to count 0..depth saved words inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flag_reg_stack_if.sv
// Control-unit <-> flag register bus. Stack_level exists only when FLAG_STACK_LEVEL_EN is defined.
interface flag_reg_stack_if
    import flag_reg_pkg::*;
#(
    parameter int NR_OF_FLAGS = DEF_NR_OF_FLAGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
);

    logic [NR_OF_FLAGS-1:0] Flag_in;
    logic [NR_OF_FLAGS-1:0] Flag_we;
    logic                   Clear_flg;
    logic                   Push;
    logic                   Pop;
    logic [NR_OF_FLAGS-1:0] Flag_reg;
    logic                   Stack_full;
    logic                   Stack_empty;
    logic                   Stack_err;
`ifdef FLAG_STACK_LEVEL_EN
    logic [level_w(STACK_DEPTH)-1:0] Stack_level;
`endif

    modport master (
        output Flag_in, Flag_we, Clear_flg, Push, Pop,
`ifdef FLAG_STACK_LEVEL_EN
        input  Stack_level,
`endif
        input  Flag_reg, Stack_full, Stack_empty, Stack_err
    );

    modport slave (
        input  Flag_in, Flag_we, Clear_flg, Push, Pop,
`ifdef FLAG_STACK_LEVEL_EN
        output Stack_level,
`endif
        output Flag_reg, Stack_full, Stack_empty, Stack_err
    );

endinterface

// File: rtl/flag_lifo_mem.sv
// Register-array LIFO: writes at level, reads at level-1, keeps the level counter and full/empty flags.
module flag_lifo_mem
    import flag_reg_pkg::*;
#(
    parameter int WIDTH = DEF_NR_OF_FLAGS,
    parameter int DEPTH = DEF_STACK_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_push_ok,
    output logic                       o_pop_ok,
    output logic                       o_ovf,
    output logic                       o_udf,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [level_w(DEPTH)-1:0]  o_level
);

    localparam int LEVEL_W = level_w(DEPTH);
    localparam int IDX_W   = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [LEVEL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;

    logic               w_push_only;
    logic               w_pop_only;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    // Simultaneous push and pop cancel out: no stack motion and no error.
    assign w_push_only = i_push & ~i_pop;
    assign w_pop_only  = i_pop & ~i_push;
    assign w_push_ok   = w_push_only & ~r_full;
    assign w_pop_ok    = w_pop_only & ~r_empty;

    assign w_wr_idx = IDX_W'(r_level);
    assign w_rd_idx = IDX_W'(r_level - LEVEL_W'(1));

    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok) begin
            w_level_nxt = r_level + LEVEL_W'(1);
        end else if (w_pop_ok) begin
            w_level_nxt = r_level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LEVEL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Saved words need no reset; a slot is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    assign o_rdata   = r_mem[w_rd_idx];
    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;
    assign o_ovf     = w_push_only & r_full;
    assign o_udf     = w_pop_only & r_empty;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/flag_reg_stack.sv
// Condition flag register with per-bit write enables, flag-only clear and a push/pop LIFO of saved flags.
// Optional FLAG_STACK_LEVEL_EN exposes the current stack level on the bus.
module flag_reg_stack
    import flag_reg_pkg::*;
#(
    parameter int NR_OF_FLAGS = DEF_NR_OF_FLAGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    flag_reg_stack_if.slave  io_bus
);

    logic [NR_OF_FLAGS-1:0] r_flag;
    logic                   r_err;

    logic [NR_OF_FLAGS-1:0] w_top;
    logic                   w_push_ok;
    logic                   w_pop_ok;
    logic                   w_ovf;
    logic                   w_udf;
    logic                   w_full;
    logic                   w_empty;
`ifdef FLAG_STACK_LEVEL_EN
    logic [level_w(STACK_DEPTH)-1:0] w_level;
`endif

    // The LIFO always saves the pre-update flags, so same-cycle writes land after the push.
    flag_lifo_mem #(
        .WIDTH (NR_OF_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (io_bus.Push),
        .i_pop     (io_bus.Pop),
        .i_wdata   (r_flag),
        .o_rdata   (w_top),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok),
        .o_ovf     (w_ovf),
        .o_udf     (w_udf),
        .o_full    (w_full),
        .o_empty   (w_empty),
`ifdef FLAG_STACK_LEVEL_EN
        .o_level   (w_level)
`else
        .o_level   ()
`endif
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag <= '0;
            r_err  <= 1'b0;
        end else begin
            if (io_bus.Clear_flg) begin
                r_flag <= '0;
            end else if (w_pop_ok) begin
                r_flag <= w_top;
            end else begin
                r_flag <= (r_flag & ~io_bus.Flag_we) | (io_bus.Flag_in & io_bus.Flag_we);
            end
            if (w_ovf || w_udf) begin
                r_err <= 1'b1;
            end
        end
    end

    // Push/pop legality is resolved inside the LIFO; only the strobes above matter here.
    logic w_unused;
    assign w_unused = w_push_ok;

    assign io_bus.Flag_reg    = r_flag;
    assign io_bus.Stack_full  = w_full;
    assign io_bus.Stack_empty = w_empty;
    assign io_bus.Stack_err   = r_err;
`ifdef FLAG_STACK_LEVEL_EN
    assign io_bus.Stack_level = w_level;
`endif

endmodule

// File: tb/tb_flag_reg_stack.sv
// Scoreboard bench for flag_reg_stack; Stack_level is checked when FLAG_STACK_LEVEL_EN is defined.
module tb_flag_reg_stack;

    localparam int NF = 4;
    localparam int SD = 4;

    typedef struct packed {
        logic [NF-1:0] flg;
        logic          full;
        logic          empty;
        logic          err;
        logic [2:0]    lvl;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_reg_stack_if #(.NR_OF_FLAGS(NF), .STACK_DEPTH(SD)) bus ();

    flag_reg_stack #(.NR_OF_FLAGS(NF), .STACK_DEPTH(SD)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    obs_t exp_q[$];
    obs_t act_q[$];
    logic [NF-1:0] m_stk[$];
    logic [NF-1:0] m_flg = '0;
    logic          m_err = 1'b0;
    int n_run  = 0;
    int n_fail = 0;

    // Apply one cycle of stimulus, advance the reference model, record expected and observed.
    task automatic drive(input logic r, input logic [NF-1:0] we, input logic [NF-1:0] din,
                         input logic clr, input logic push, input logic pop);
        int lvl;
        logic push_ok, pop_ok, ovf, udf;
        logic [NF-1:0] nf;
        obs_t e, a;
        rst = r; bus.Flag_we = we; bus.Flag_in = din;
        bus.Clear_flg = clr; bus.Push = push; bus.Pop = pop;
        @(posedge clk);
        #1;
        if (r) begin
            m_flg = '0; m_stk.delete(); m_err = 1'b0;
        end else begin
            lvl     = m_stk.size();
            push_ok = push && !pop && (lvl < SD);
            pop_ok  = pop && !push && (lvl > 0);
            ovf     = push && !pop && (lvl == SD);
            udf     = pop && !push && (lvl == 0);
            if (clr)         nf = '0;
            else if (pop_ok) nf = m_stk[lvl-1];
            else             nf = (m_flg & ~we) | (din & we);
            if (push_ok) m_stk.push_back(m_flg);
            if (pop_ok)  void'(m_stk.pop_back());
            if (ovf || udf) m_err = 1'b1;
            m_flg = nf;
        end
        e.flg = m_flg; e.err = m_err;
        e.full = (m_stk.size() == SD); e.empty = (m_stk.size() == 0);
        a.flg = bus.Flag_reg; a.err = bus.Stack_err;
        a.full = bus.Stack_full; a.empty = bus.Stack_empty;
`ifdef FLAG_STACK_LEVEL_EN
        e.lvl = 3'(m_stk.size());
        a.lvl = bus.Stack_level;
`else
        e.lvl = 3'd0;
        a.lvl = 3'd0;
`endif
        exp_q.push_back(e);
        act_q.push_back(a);
    endtask

    task automatic test_reset();
        obs_t e, a;
        drive(1, '0, '0, 0, 0, 0);
        drive(1, 4'hF, 4'hF, 1, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
        n_run++;
        if ({bus.Flag_reg, bus.Stack_empty, bus.Stack_full, bus.Stack_err} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_const: got flg=%b empty=%b full=%b err=%b, want 0000 1 0 0",
                     bus.Flag_reg, bus.Stack_empty, bus.Stack_full, bus.Stack_err);
        end
    endtask

    task automatic test_write();
        obs_t e, a;
        drive(0, 4'b1111, 4'b1010, 0, 0, 0);
        n_run++;
        if (bus.Flag_reg !== 4'b1010) begin
            n_fail++;
            $display("FAIL write_const: got flg=%b, want 1010", bus.Flag_reg);
        end
        drive(0, 4'b0110, 4'b0000, 0, 0, 0);
        drive(0, 4'b0110, 4'b0110, 0, 0, 0);
        drive(0, 4'b1111, 4'b1010, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL write: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_push_write_pop();
        obs_t e, a;
        drive(0, 4'b0001, 4'b0101, 0, 1, 0);
        n_run++;
        if (bus.Flag_reg !== 4'b1011) begin
            n_fail++;
            $display("FAIL push_write_const: got flg=%b, want 1011", bus.Flag_reg);
        end
        drive(0, 4'b1111, 4'b0000, 0, 0, 1);
        n_run++;
        if ({bus.Flag_reg, bus.Stack_empty} !== {4'b1010, 1'b1}) begin
            n_fail++;
            $display("FAIL pop_restore_const: got flg=%b empty=%b, want 1010 1", bus.Flag_reg, bus.Stack_empty);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL push_write_pop: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_full_overflow();
        obs_t e, a;
        logic [NF-1:0] order [4];
        order[0] = 4'd4; order[1] = 4'd3; order[2] = 4'd2; order[3] = 4'd1;
        drive(0, 4'hF, 4'd1, 0, 0, 0);
        drive(0, 4'hF, 4'd2, 0, 1, 0);
        drive(0, 4'hF, 4'd3, 0, 1, 0);
        drive(0, 4'hF, 4'd4, 0, 1, 0);
        drive(0, 4'h0, 4'd0, 0, 1, 0);
        n_run++;
        if ({bus.Stack_full, bus.Stack_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_const: got full=%b err=%b, want 1 0", bus.Stack_full, bus.Stack_err);
        end
        drive(0, 4'hF, 4'd5, 0, 1, 0);
        n_run++;
        if ({bus.Stack_full, bus.Stack_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL overflow_const: got full=%b err=%b, want 1 1", bus.Stack_full, bus.Stack_err);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'h0, 4'd0, 0, 0, 1);
            n_run++;
            if (bus.Flag_reg !== order[i]) begin
                n_fail++;
                $display("FAIL pop_order%0d: got flg=%0d, want %0d", i, bus.Flag_reg, order[i]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL full_overflow: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_underflow();
        obs_t e, a;
        drive(1, '0, '0, 0, 0, 0);
        drive(0, 4'b1000, 4'b1000, 0, 0, 1);
        n_run++;
        if ({bus.Flag_reg, bus.Stack_err, bus.Stack_empty} !== {4'b1000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow_const: got flg=%b err=%b empty=%b, want 1000 1 1",
                     bus.Flag_reg, bus.Stack_err, bus.Stack_empty);
        end
        drive(0, 4'b0000, 4'b0000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL underflow: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_push_pop_same();
        obs_t e, a;
        drive(1, '0, '0, 0, 0, 0);
        drive(0, 4'hF, 4'b0110, 0, 0, 0);
        drive(0, 4'h0, 4'h0, 0, 1, 0);
        drive(0, 4'hF, 4'b1001, 0, 1, 0);
        drive(0, 4'h0, 4'hF, 0, 1, 1);
        n_run++;
        if ({bus.Flag_reg, bus.Stack_err} !== {4'b1001, 1'b0}) begin
            n_fail++;
            $display("FAIL push_pop_same_const: got flg=%b err=%b, want 1001 0", bus.Flag_reg, bus.Stack_err);
        end
        drive(0, 4'h0, 4'h0, 1, 0, 1);
        drive(0, 4'h0, 4'h0, 0, 0, 1);
        n_run++;
        if ({bus.Flag_reg, bus.Stack_empty} !== {4'b0110, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_pop_const: got flg=%b empty=%b, want 0110 1", bus.Flag_reg, bus.Stack_empty);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL push_pop_same: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, a;
        drive(0, 4'h0, 4'h0, 0, 0, 1);
        drive(0, 4'hF, 4'd7, 0, 1, 0);
        drive(0, 4'hF, 4'd9, 0, 1, 0);
        drive(0, 4'hF, 4'd12, 0, 1, 0);
        drive(1, 4'hF, 4'hF, 0, 1, 0);
        n_run++;
        if ({bus.Flag_reg, bus.Stack_empty, bus.Stack_full, bus.Stack_err} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_const: got flg=%b empty=%b full=%b err=%b, want 0000 1 0 0",
                     bus.Flag_reg, bus.Stack_empty, bus.Stack_full, bus.Stack_err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_mid: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        drive(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            drive(0, 4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_run++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL back_to_back: got flg=%b full=%b empty=%b err=%b lvl=%0d, want flg=%b full=%b empty=%b err=%b lvl=%0d",
                         a.flg, a.full, a.empty, a.err, a.lvl, e.flg, e.full, e.empty, e.err, e.lvl);
            end
        end
    endtask

    initial begin
        bus.Flag_in = '0; bus.Flag_we = '0;
        bus.Clear_flg = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0;
        test_reset();
        test_write();
        test_push_write_pop();
        test_full_overflow();
        test_underflow();
        test_push_pop_same();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
